// File: rtl/umtrx_pkt_pkg.sv
// umtrx_pkt_pkg
//   Shared definitions for the UmTRX 36-bit packet-stream blocks:
//   line-field bit positions, the packet mux state encoding and the
//   control-register bit layout.
package umtrx_pkt_pkg;

  localparam int unsigned LINE_W  = 36;

  // Line format: {occupancy[1:0], eof, sof, data[31:0]}
  localparam int unsigned SOF_BIT = 32;
  localparam int unsigned EOF_BIT = 33;
  localparam int unsigned OCC_MSB = 35;
  localparam int unsigned OCC_LSB = 34;

  // Control register: bits[NUM_CH-1:0] enable mask, bit 31 counter clear
  localparam int unsigned CLR_BIT = 31;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    DROP = 2'd2
  } pkt_state_t;

endpackage

// File: rtl/umtrx_rr_pick.sv
// umtrx_rr_pick
//   Combinational round-robin priority picker. Returns the first requester
//   at or after last+1 (modulo N).
//   Ports:
//     req   [N-1:0]   request vector
//     last  [IW-1:0]  index granted most recently
//     found           at least one request present
//     idx   [IW-1:0]  winning index (0 when found is low)
module umtrx_rr_pick #(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          found,
  output logic [IW-1:0] idx
);

  always_comb begin
    int unsigned c;
    logic [IW-1:0] ci;
    found = 1'b0;
    idx   = '0;
    c     = 0;
    ci    = '0;
    // Walk the ring starting just after the previous winner; the last
    // probe (k == N) revisits 'last' itself so a lone requester still wins.
    for (int unsigned k = 1; k <= N; k++) begin
      c  = (32'(last) + k) % N;
      ci = IW'(c);
      if (!found && req[ci]) begin
        found = 1'b1;
        idx   = ci;
      end
    end
  end

endmodule

// File: rtl/umtrx_err_pkt_mux.sv
// umtrx_err_pkt_mux
//   Packet-aware round-robin merge of NUM_CH error/flow-control streams onto
//   one output stream. Whole packets are taken from one channel at a time;
//   packets from channels disabled in the control register are drained and
//   discarded. Forwarded and dropped packets are counted.
//   Ports:
//     sys_clk, sys_rst              clock, async active-high reset
//     set_stb/set_addr/set_data     settings bus (control reg at BASE)
//     in_data/in_valid/in_ready     NUM_CH packed input streams
//     out_data/out_valid/out_ready  merged output stream
//     status                        {drop_count, pkt_count}
//     busy                          packet in flight (PASS or DROP)
module umtrx_err_pkt_mux
  import umtrx_pkt_pkg::*;
#(
  parameter int unsigned NUM_CH = 2,
  parameter logic [7:0]  BASE   = 8'd0
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic                     set_stb,
  input  logic [7:0]               set_addr,
  input  logic [31:0]              set_data,
  input  logic [LINE_W*NUM_CH-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_ready,
  output logic [LINE_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              status,
  output logic                     busy
);

  localparam int unsigned GW = $clog2(NUM_CH);

  pkt_state_t        state, state_nxt;
  logic [GW-1:0]     grant, grant_nxt;
  logic [GW-1:0]     last_grant, last_grant_nxt;
  logic [NUM_CH-1:0] mask;
  logic              clr_pend;
  logic [15:0]       pkt_count, drop_count;
  logic              pkt_inc, drop_inc;
  logic              pick_found;
  logic [GW-1:0]     pick_idx;
  logic [LINE_W-1:0] cur_line;
  logic              cur_valid;
  logic              ctrl_hit;
  logic              unused_set_bits;

  assign ctrl_hit        = set_stb && (set_addr == BASE);
  assign unused_set_bits = ^set_data[CLR_BIT-1:NUM_CH];

  assign cur_line  = in_data[LINE_W*32'(grant) +: LINE_W];
  assign cur_valid = in_valid[grant];

  umtrx_rr_pick #(
    .N  (NUM_CH),
    .IW (GW)
  ) u_pick (
    .req   (in_valid),
    .last  (last_grant),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Settings: the mask register updates immediately, but it is only
  // consulted when a new grant is issued in IDLE, so an in-flight packet
  // finishes under the decision made at its grant.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      mask     <= '1;
      clr_pend <= 1'b0;
    end else begin
      clr_pend <= ctrl_hit && set_data[CLR_BIT];
      if (ctrl_hit)
        mask <= set_data[NUM_CH-1:0];
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= GW'(NUM_CH - 1);
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    out_data       = '0;
    out_valid      = 1'b0;
    in_ready       = '0;
    pkt_inc        = 1'b0;
    drop_inc       = 1'b0;
    case (state)
      IDLE: begin
        if (pick_found) begin
          grant_nxt = pick_idx;
          state_nxt = mask[pick_idx] ? PASS : DROP;
        end
      end
      PASS: begin
        out_data        = cur_line;
        out_valid       = cur_valid;
        in_ready[grant] = out_ready;
        if (cur_valid && out_ready && cur_line[EOF_BIT]) begin
          pkt_inc        = 1'b1;
          last_grant_nxt = grant;
          state_nxt      = IDLE;
        end
      end
      DROP: begin
        in_ready[grant] = 1'b1;
        if (cur_valid && cur_line[EOF_BIT]) begin
          drop_inc       = 1'b1;
          last_grant_nxt = grant;
          state_nxt      = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Clear is registered one cycle behind the strobe and overrides any
  // increment landing in the same cycle.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      pkt_count  <= '0;
      drop_count <= '0;
    end else if (clr_pend) begin
      pkt_count  <= '0;
      drop_count <= '0;
    end else begin
      if (pkt_inc)
        pkt_count <= pkt_count + 16'd1;
      if (drop_inc)
        drop_count <= drop_count + 16'd1;
    end
  end

  assign status = {drop_count, pkt_count};
  assign busy   = (state != IDLE);

endmodule

// File: tb/tb_umtrx_err_pkt_mux.sv
// tb_umtrx_err_pkt_mux
//   Self-checking bench for umtrx_err_pkt_mux: table-driven single-packet
//   vectors, directed multi-packet sequences and randomized traffic scored
//   at packet level (per-channel ordered line queues, whole-packet output,
//   counter totals).
module tb_umtrx_err_pkt_mux;
  import umtrx_pkt_pkg::*;

  localparam int unsigned NUM_CH = 2;
  localparam logic [7:0]  BASE   = 8'h40;

  logic                     sys_clk;
  logic                     sys_rst;
  logic                     set_stb;
  logic [7:0]               set_addr;
  logic [31:0]              set_data;
  logic [LINE_W*NUM_CH-1:0] in_data;
  logic [NUM_CH-1:0]        in_valid;
  logic [NUM_CH-1:0]        in_ready;
  logic [LINE_W-1:0]        out_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [31:0]              status;
  logic                     busy;

  umtrx_err_pkt_mux #(
    .NUM_CH (NUM_CH),
    .BASE   (BASE)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .set_stb   (set_stb),
    .set_addr  (set_addr),
    .set_data  (set_data),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .status    (status),
    .busy      (busy)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // ---------------------------------------------------------------- state
  int unsigned      n_vec = 0;
  int unsigned      n_err = 0;
  logic [35:0]      src_q [NUM_CH][$];
  logic [35:0]      exp_q [NUM_CH][$];
  int unsigned      cyc = 0;
  int unsigned      ready_mode = 0;   // 0 always, 1 toggle, 2 random
  int unsigned      valid_pct [NUM_CH];
  int unsigned      rdy_cnt [NUM_CH];
  int unsigned      out_cnt = 0;
  int               first_req_cyc = -1;
  int               first_out_cyc = -1;
  bit               sb_in_pkt = 1'b0;
  int unsigned      sb_ch = 0;
  int               last_eof_cyc = -100;
  int               last_gap = 0;
  int unsigned      pkt_order [$];
  int unsigned      m_pkt = 0;
  int unsigned      m_drop = 0;
  logic [NUM_CH-1:0] m_mask = '1;
  int unsigned      pid = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Packet-level scoreboard for every accepted output line.
  function automatic void score(logic [35:0] line, int unsigned tcyc);
    int unsigned ch;
    logic [35:0] e;
    ch = 32'(line[31:24]);
    out_cnt++;
    if (!sb_in_pkt) begin
      last_gap = int'(tcyc) - last_eof_cyc;
      chk("pkt_gap_ge2", 64'(last_gap >= 2), 64'd1);
      pkt_order.push_back(ch);
      sb_ch = ch;
    end else begin
      chk("no_interleave", 64'(ch), 64'(sb_ch));
    end
    if (ch < NUM_CH && exp_q[ch].size() > 0) begin
      e = exp_q[ch].pop_front();
      chk("out_line", 64'(line), 64'(e));
    end else begin
      n_vec++;
      n_err++;
      $display("FAIL unexpected_line: got 0x%0h, expected no line (cycle %0d)", line, tcyc);
    end
    sb_in_pkt = !line[EOF_BIT];
    if (line[EOF_BIT]) last_eof_cyc = int'(tcyc);
  endfunction

  // Source/sink engine: sample on negedge, act on the following posedge.
  initial begin : engine
    bit take [NUM_CH];
    bit otake;
    logic [35:0] oline;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b1;
    for (int c = 0; c < NUM_CH; c++) begin
      valid_pct[c] = 100;
      rdy_cnt[c]   = 0;
    end
    forever begin
      @(negedge sys_clk);
      for (int c = 0; c < NUM_CH; c++) begin
        take[c] = in_valid[c] && in_ready[c];
        if (in_valid[c] && first_req_cyc < 0) first_req_cyc = int'(cyc);
      end
      otake = out_valid && out_ready;
      oline = out_data;
      if (out_valid && first_out_cyc < 0) first_out_cyc = int'(cyc);
      @(posedge sys_clk);
      cyc++;
      #1;
      for (int c = 0; c < NUM_CH; c++) begin
        if (take[c] && src_q[c].size() > 0) begin
          void'(src_q[c].pop_front());
          rdy_cnt[c]++;
        end
      end
      if (otake) score(oline, cyc - 1);
      for (int c = 0; c < NUM_CH; c++) begin
        if (src_q[c].size() > 0 && $urandom_range(99) < valid_pct[c]) begin
          in_valid[c] = 1'b1;
          in_data[c*36 +: 36] = src_q[c][0];
        end else begin
          in_valid[c] = 1'b0;
          in_data[c*36 +: 36] = '0;
        end
      end
      case (ready_mode)
        1:       out_ready = ~out_ready;
        2:       out_ready = 1'($urandom_range(1));
        default: out_ready = 1'b1;
      endcase
    end
  end

  // ---------------------------------------------------------------- tasks
  task automatic tick(int unsigned n);
    repeat (n) @(posedge sys_clk);
    #2;
  endtask

  task automatic push_pkt(int unsigned ch, int unsigned len, bit fwd);
    logic [35:0] line;
    for (int unsigned i = 0; i < len; i++) begin
      line = {2'($urandom_range(3)), (i == len - 1), (i == 0), 8'(ch), 8'(pid), 16'(i)};
      src_q[ch].push_back(line);
      if (fwd) exp_q[ch].push_back(line);
    end
    pid++;
    if (fwd) m_pkt++;
    else     m_drop++;
  endtask

  task automatic write_ctrl(logic [7:0] addr, logic [31:0] data);
    set_stb  = 1'b1;
    set_addr = addr;
    set_data = data;
    tick(1);
    set_stb  = 1'b0;
    if (addr == BASE) begin
      m_mask = data[NUM_CH-1:0];
      if (data[CLR_BIT]) begin
        m_pkt  = 0;
        m_drop = 0;
      end
    end
  endtask

  task automatic wait_drain(string name, int unsigned max);
    int unsigned n = 0;
    int unsigned left;
    bit done = 1'b0;
    while (!done && n < max) begin
      tick(1);
      n++;
      left = 0;
      for (int c = 0; c < NUM_CH; c++) left += src_q[c].size();
      done = (left == 0) && !busy;
    end
    chk({name, "_drain"}, 64'(done), 64'd1);
    tick(2);
    left = 0;
    for (int c = 0; c < NUM_CH; c++) left += exp_q[c].size();
    chk({name, "_exp_left"}, 64'(left), 64'd0);
  endtask

  task automatic wait_out(string name, int unsigned n_lines, int unsigned max);
    int unsigned n = 0;
    while (out_cnt < n_lines && n < max) begin
      tick(1);
      n++;
    end
    chk({name, "_reached"}, 64'(out_cnt >= n_lines), 64'd1);
  endtask

  task automatic flush_model();
    for (int c = 0; c < NUM_CH; c++) begin
      src_q[c].delete();
      exp_q[c].delete();
    end
    sb_in_pkt = 1'b0;
    m_pkt     = 0;
    m_drop    = 0;
    m_mask    = '1;
  endtask

  // ---------------------------------------------------------------- vectors
  typedef struct {
    int unsigned ch;
    int unsigned len;
    logic [7:0]  addr;
    logic [1:0]  wmask;
    int unsigned exp_out;
    int unsigned exp_pkt;
    int unsigned exp_drop;
  } vec_t;

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t tbl [8];
    tbl[0] = '{ch:0, len:3, addr:BASE,      wmask:2'b11, exp_out:3, exp_pkt:1, exp_drop:0};
    tbl[1] = '{ch:1, len:1, addr:BASE,      wmask:2'b11, exp_out:1, exp_pkt:2, exp_drop:0};
    tbl[2] = '{ch:1, len:5, addr:BASE,      wmask:2'b01, exp_out:0, exp_pkt:2, exp_drop:1};
    tbl[3] = '{ch:0, len:2, addr:BASE,      wmask:2'b01, exp_out:2, exp_pkt:3, exp_drop:1};
    tbl[4] = '{ch:0, len:4, addr:BASE,      wmask:2'b10, exp_out:0, exp_pkt:3, exp_drop:2};
    tbl[5] = '{ch:1, len:1, addr:BASE,      wmask:2'b00, exp_out:0, exp_pkt:3, exp_drop:3};
    tbl[6] = '{ch:0, len:2, addr:BASE + 1,  wmask:2'b11, exp_out:0, exp_pkt:3, exp_drop:4};
    tbl[7] = '{ch:1, len:6, addr:BASE,      wmask:2'b11, exp_out:6, exp_pkt:4, exp_drop:4};

    set_stb  = 1'b0;
    set_addr = '0;
    set_data = '0;
    sys_rst  = 1'b0;
    #2 sys_rst = 1'b1;
    repeat (3) @(posedge sys_clk);
    #2;
    chk("rst_busy",      64'(busy),      64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd0);
    chk("rst_status",    64'(status),    64'd0);
    sys_rst = 1'b0;
    tick(2);

    // Table: one packet per vector, cumulative counters from reset.
    for (int i = 0; i < 8; i++) begin
      write_ctrl(tbl[i].addr, {30'd0, tbl[i].wmask});
      out_cnt = 0;
      rdy_cnt[tbl[i].ch] = 0;
      first_req_cyc = -1;
      first_out_cyc = -1;
      push_pkt(tbl[i].ch, tbl[i].len, m_mask[tbl[i].ch]);
      wait_drain($sformatf("tbl%0d", i), 100);
      chk($sformatf("tbl%0d_out_lines", i), 64'(out_cnt), 64'(tbl[i].exp_out));
      chk($sformatf("tbl%0d_accepted", i), 64'(rdy_cnt[tbl[i].ch]), 64'(tbl[i].len));
      chk($sformatf("tbl%0d_status", i), 64'(status),
          64'({16'(tbl[i].exp_drop), 16'(tbl[i].exp_pkt)}));
      chk($sformatf("tbl%0d_busy", i), 64'(busy), 64'd0);
      if (tbl[i].exp_out > 0)
        chk($sformatf("tbl%0d_latency", i), 64'(first_out_cyc - first_req_cyc), 64'd1);
    end

    // A: both channels valid together; last winner was ch1 so ch0 goes first.
    out_cnt = 0;
    pkt_order.delete();
    push_pkt(0, 4, 1'b1);
    push_pkt(1, 4, 1'b1);
    wait_drain("A", 100);
    chk("A_out_lines", 64'(out_cnt), 64'd8);
    chk("A_npkts", 64'(pkt_order.size()), 64'd2);
    chk("A_order0", 64'(pkt_order.size() > 0 ? pkt_order[0] : 99), 64'd0);
    chk("A_order1", 64'(pkt_order.size() > 1 ? pkt_order[1] : 99), 64'd1);
    chk("A_gap", 64'(last_gap), 64'd2);
    chk("A_status", 64'(status), 64'({16'(m_drop), 16'(m_pkt)}));

    // B: ch1 continuously valid, ch0 two packets -> alternation.
    pkt_order.delete();
    push_pkt(1, 3, 1'b1);
    push_pkt(1, 3, 1'b1);
    push_pkt(0, 2, 1'b1);
    push_pkt(0, 2, 1'b1);
    wait_drain("B", 200);
    chk("B_order0", 64'(pkt_order.size() > 0 ? pkt_order[0] : 99), 64'd0);
    chk("B_order1", 64'(pkt_order.size() > 1 ? pkt_order[1] : 99), 64'd1);
    chk("B_order2", 64'(pkt_order.size() > 2 ? pkt_order[2] : 99), 64'd0);
    chk("B_order3", 64'(pkt_order.size() > 3 ? pkt_order[3] : 99), 64'd1);

    // C: mask ch1 off while its packet is mid-flight; the rest still passes,
    // its next packet is dropped.
    out_cnt = 0;
    rdy_cnt[1] = 0;
    push_pkt(1, 4, 1'b1);
    push_pkt(1, 3, 1'b0);
    wait_out("C_line2", 2, 50);
    write_ctrl(BASE, 32'h1);
    wait_drain("C", 100);
    chk("C_out_lines", 64'(out_cnt), 64'd4);
    chk("C_accepted", 64'(rdy_cnt[1]), 64'd7);
    chk("C_status", 64'(status), 64'({16'(m_drop), 16'(m_pkt)}));

    // D: out_ready toggling, then counter clear.
    write_ctrl(BASE, 32'h3);
    out_cnt = 0;
    ready_mode = 1;
    push_pkt(0, 6, 1'b1);
    wait_drain("D", 100);
    ready_mode = 0;
    chk("D_out_lines", 64'(out_cnt), 64'd6);
    chk("D_status_pre", 64'(status), 64'({16'(m_drop), 16'(m_pkt)}));
    write_ctrl(BASE, 32'h8000_0000);
    tick(1);
    chk("D_status_clr", 64'(status), 64'd0);
    write_ctrl(BASE, 32'h3);

    // E: reset in the middle of a packet.
    push_pkt(1, 1, 1'b1);
    wait_drain("E_pre", 50);
    chk("E_status_pre", 64'(status), 64'h0000_0001);
    out_cnt = 0;
    push_pkt(0, 8, 1'b1);
    wait_out("E_line3", 3, 50);
    sys_rst = 1'b1;
    #1;
    chk("E_rst_busy",      64'(busy),      64'd0);
    chk("E_rst_out_valid", 64'(out_valid), 64'd0);
    chk("E_rst_in_ready",  64'(in_ready),  64'd0);
    chk("E_rst_status",    64'(status),    64'd0);
    flush_model();
    tick(2);
    sys_rst = 1'b0;
    tick(2);

    // Random traffic; phase 0 relies on the reset mask (all enabled).
    for (int p = 0; p < 5; p++) begin
      int unsigned ch;
      if (p > 0) write_ctrl(BASE, 32'($urandom_range(3)));
      for (int c = 0; c < NUM_CH; c++) valid_pct[c] = $urandom_range(30, 100);
      ready_mode = (p == 0) ? 0 : $urandom_range(2);
      for (int k = 0; k < 8; k++) begin
        ch = $urandom_range(NUM_CH - 1);
        push_pkt(ch, $urandom_range(1, 6), m_mask[ch]);
      end
      wait_drain($sformatf("rnd%0d", p), 2000);
      chk($sformatf("rnd%0d_status", p), 64'(status), 64'({16'(m_drop), 16'(m_pkt)}));
    end
    ready_mode = 0;
    for (int c = 0; c < NUM_CH; c++) valid_pct[c] = 100;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/umtrx_err_pkt_mux.md
Name: umtrx_err_pkt_mux

Overview:
- Packet-aware round-robin arbiter that merges the 36-bit error/flow-control packet streams of NUM_CH TX chains onto one sys-clock stream toward the router.
- Each output packet is taken whole from a single channel and never interleaved.
- A settings register enables or disables channels. Packets from disabled channels are drained and discarded, so a stalled chain cannot back up its FIFO.
- Forwarded and dropped packets are counted for host readback.

Parameters:
- NUM_CH, 2: number of input streams (2..8).
- BASE, 0: settings-bus address of the control register.

Ports:
- sys_clk  in  1  clock. Everything runs in this domain.
- sys_rst  in  1  reset, asynchronous, active-high.
- set_stb  in  1  settings write strobe.
- set_addr  in  8  settings address.
- set_data  in  32  settings data.
- in_data  in  36*NUM_CH  channel c occupies bits [36c+35:36c].
- in_valid  in  NUM_CH  per-channel valid.
- in_ready  out  NUM_CH  per-channel ready.
- out_data  out  36  merged line.
- out_valid  out  1  merged valid.
- out_ready  in  1  downstream ready.
- status  out  32  {drop_count[15:0], pkt_count[15:0]}.
- busy  out  1  high while a packet is in flight (state PASS or DROP).

Behaviour:
- Line format: bit32 = SOF, bit33 = EOF, bits[35:34] = occupancy. Occupancy is passed through untouched. A transfer occurs when valid and ready are both high.
- Control register: write at set_addr == BASE.
  - Bits[NUM_CH-1:0] = enable mask.
  - Bit31 = 1 clears both counters, taking effect the cycle after the strobe.
  - Reset value of the mask: all ones.
  - A mask change takes effect only at packet boundaries. The channel currently granted completes its packet under the old decision.
- Reset values: state IDLE, grant 0, last_grant NUM_CH-1 (so channel 0 wins first), counters 0, out_valid 0, in_ready all 0, busy 0.
- State IDLE:
  - out_valid = 0 and all in_ready = 0.
  - Candidates are channels with in_valid high. Enabled and disabled channels compete in the same round-robin.
  - The winner is the first candidate at or after last_grant+1, modulo NUM_CH.
  - The grant is registered. The next state is PASS if the winner is enabled, DROP if it is disabled.
  - With no candidate, stay in IDLE.
- State PASS:
  - out_data = in_data[grant] and out_valid = in_valid[grant], both combinational.
  - in_ready[grant] = out_ready. Every other in_ready = 0.
  - On a transfer of a line with EOF=1: pkt_count++, last_grant <= grant, go to IDLE.
- State DROP:
  - in_ready[grant] = 1, out_valid = 0.
  - On a transfer of a line with EOF=1: drop_count++, last_grant <= grant, go to IDLE.
- Latency and throughput:
  - First line reaches the output one cycle after the request is seen in IDLE.
  - Data path within a packet: zero added latency, full throughput.
  - One idle cycle between packets.
- SOF is not checked. The first line after a grant is treated as the packet start.
- A single-line packet (SOF and EOF both set) completes in one transfer.
- Counters are 16-bit and wrap from 0xFFFF to 0.
- If a clear and an increment happen in the same cycle, the clear wins.
- The grant does not change mid-packet under any input pattern, including in_valid dropping low or a mask write.
- sys_rst asserted mid-packet returns to the reset state immediately. The partial packet is abandoned, and downstream must tolerate the truncation.

Decomposition:
- Shared package umtrx_pkt_pkg holds:
  - line-field constants: SOF_BIT = 32, EOF_BIT = 33, OCC_MSB = 35, OCC_LSB = 34;
  - state encoding IDLE / PASS / DROP;
  - the control-register bit positions (CLR_BIT = 31).
- Sub-module umtrx_rr_pick: combinational round-robin priority picker taking (req, last) and returning (found, idx). It is reusable for the command-packet path.

Test Plan:
- Reset, then channel 0 sends a 3-line packet (SOF, -, EOF) with out_ready held high → 3 output lines identical to the input, one cycle after the request; pkt_count = 1; busy low afterwards.
- Both channels hold a 4-line packet valid simultaneously → ch0's packet is output whole, one idle cycle, then ch1's packet whole; pkt_count = 2; no interleaving.
- ch1 is continuously valid and ch0 sends 2 packets → output order is ch0, ch1, ch0 (round-robin fairness).
- Write mask 0x1 via the settings bus, then ch1 sends a 5-line packet → in_ready[1] high for 5 cycles; no output; drop_count = 1; pkt_count unchanged.
- Write mask 0x1 while ch1's PASS packet is at line 2 of 4 → remaining 2 lines are still forwarded; ch1's next packet is dropped.
- out_ready toggles 1010… during a packet, then write 0x80000000 → data intact with no duplicated or lost lines; next cycle status = 0.
